// File: rtl/platform_bank_if.sv
// Platform bank bus: scroll request/amount in from jump logic, platform geometry,
// live flags and height score back out to the jump-logic collision stage.
interface platform_bank_if;
  logic         loadplat;
  logic         refresh_en;
  logic [9:0]   scroll_amt;
  logic [143:0] plat_x;
  logic [143:0] plat_y;
  logic [15:0]  plat_valid;
  logic [8:0]   plat_size_x;
  logic [8:0]   plat_size_y;
  logic         busy;
  logic [15:0]  score;

  // Jump-logic / stimulus side.
  modport master (
    output loadplat, refresh_en, scroll_amt,
    input  plat_x, plat_y, plat_valid, plat_size_x, plat_size_y, busy, score
  );

  // Platform bank side.
  modport slave (
    input  loadplat, refresh_en, scroll_amt,
    output plat_x, plat_y, plat_valid, plat_size_x, plat_size_y, busy, score
  );
endinterface

// File: rtl/platform_bank.sv
// Platform bank: owns the 16 on-screen platforms. Lays them out on a loadplat
// rising edge, scrolls them down on refresh_en, kills platforms that leave the
// bottom edge, respawns one dead slot per frame at the top, and keeps a
// saturating height score.
// Optional feature macro: PLAT_DRIFT_EN (odd slots drift horizontally).
module platform_bank #(
  parameter logic [8:0]  PLAT_SIZE_X  = 9'd20,
  parameter logic [8:0]  PLAT_SIZE_Y  = 9'd3,
  parameter logic [9:0]  SCREEN_Y_MAX = 10'd479,
  parameter logic [9:0]  SPAWN_Y      = 10'd25,
  parameter logic [9:0]  LOAD_Y0      = 10'd470,
  parameter logic [9:0]  X_MIN        = 10'd40,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic            frame_clk,
  input logic            Reset,
  platform_bank_if.slave bus
);

  // Slot count is fixed by the packed output widths the jump logic expects.
  localparam int unsigned NUM_PLAT = 16;

`ifdef PLAT_DRIFT_EN
  // Drift needs the full 10-bit X to detect the right-hand bound.
  localparam int unsigned XW    = 10;
  localparam logic [9:0]  X_MAX = X_MIN + 10'd510;
`else
  // Without drift only the 9 bits driven on plat_x are ever observed.
  localparam int unsigned XW = 9;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            loadplat_q;
  logic [XW-1:0]   x_q [NUM_PLAT];
  logic [XW-1:0]   x_d [NUM_PLAT];
  logic [9:0]      y_q [NUM_PLAT];
  logic [9:0]      y_d [NUM_PLAT];
  logic [15:0]     valid_q, valid_d;
  logic [15:0]     score_q, score_d;
`ifdef PLAT_DRIFT_EN
  logic [15:0]     dir_q, dir_d;   // 1 = moving right
`endif

  logic            load_rise;
  logic [XW-1:0]   new_x;
  logic [9:0]      load_y;
  logic [10:0]     scroll_sum [NUM_PLAT];
  logic [16:0]     score_sum;
  logic            resp_found;
  logic [3:0]      resp_idx;

  assign load_rise = bus.loadplat & ~loadplat_q;
  assign new_x     = XW'(X_MIN) + XW'({lfsr_q[7:0], 1'b0});
  assign load_y    = LOAD_Y0 - (10'(idx_q) * 10'd30);
  assign score_sum = {1'b0, score_q} + {7'd0, bus.scroll_amt};

  // Galois LFSR, right shift; free-runs in every state.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Per-slot scrolled Y with carry; the carry marks a wrap that kills the slot.
  always_comb begin
    for (int i = 0; i < NUM_PLAT; i++) begin
      scroll_sum[i] = {1'b0, y_q[i]} + {1'b0, bus.scroll_amt};
    end
  end

  // Lowest-index dead slot is the single respawn candidate this frame.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = 4'd0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        resp_found = 1'b1;
        resp_idx   = 4'(i);
      end
    end
  end

  // FSM next state plus slot/score updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    score_d = score_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef PLAT_DRIFT_EN
    dir_d   = dir_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (load_rise) begin
          state_d = StLoad;
          idx_d   = 4'd0;
          score_d = 16'd0;
        end
      end

      StLoad: begin
        // loadplat edges and refresh_en are deliberately ignored here.
        x_d[idx_q]     = new_x;
        y_d[idx_q]     = load_y;
        valid_d[idx_q] = 1'b1;
`ifdef PLAT_DRIFT_EN
        dir_d[idx_q]   = 1'b1;
`endif
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(NUM_PLAT - 1)) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (load_rise) begin
          // Restart takes priority over this frame's scroll.
          state_d = StLoad;
          idx_d   = 4'd0;
          score_d = 16'd0;
        end else begin
          if (bus.refresh_en) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
              if (valid_q[i]) begin
                y_d[i] = scroll_sum[i][9:0];
                if (scroll_sum[i][10] || (scroll_sum[i][9:0] > SCREEN_Y_MAX)) begin
                  valid_d[i] = 1'b0;
                end
              end
            end
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          end

`ifdef PLAT_DRIFT_EN
          for (int i = 1; i < NUM_PLAT; i += 2) begin
            if (valid_q[i]) begin
              if (dir_q[i]) begin
                x_d[i] = x_q[i] + 10'd1;
                if ((x_q[i] + 10'd1) >= X_MAX) dir_d[i] = 1'b0;
              end else begin
                x_d[i] = x_q[i] - 10'd1;
                if ((x_q[i] - 10'd1) <= X_MIN) dir_d[i] = 1'b1;
              end
            end
          end
`endif

          // Respawn overrides any scroll on the same slot; slots killed this
          // frame are still valid_q here, so they wait until next frame.
          if (resp_found) begin
            y_d[resp_idx]     = SPAWN_Y;
            x_d[resp_idx]     = new_x;
            valid_d[resp_idx] = 1'b1;
`ifdef PLAT_DRIFT_EN
            dir_d[resp_idx]   = 1'b1;
`endif
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, asynchronously cleared by Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      lfsr_q     <= LFSR_SEED;
      loadplat_q <= 1'b0;
      valid_q    <= 16'd0;
      score_q    <= 16'd0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= 10'h1FF;
      end
`ifdef PLAT_DRIFT_EN
      dir_q      <= 16'hFFFF;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      loadplat_q <= bus.loadplat;
      valid_q    <= valid_d;
      score_q    <= score_d;
      x_q        <= x_d;
      y_q        <= y_d;
`ifdef PLAT_DRIFT_EN
      dir_q      <= dir_d;
`endif
    end
  end

  // Pack slot registers onto the jump-logic buses (low 9 bits of each).
  always_comb begin
    bus.plat_x = '0;
    bus.plat_y = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      bus.plat_x[9*i +: 9] = x_q[i][8:0];
      bus.plat_y[9*i +: 9] = y_q[i][8:0];
    end
  end

  assign bus.plat_valid  = valid_q;
  assign bus.plat_size_x = PLAT_SIZE_X;
  assign bus.plat_size_y = PLAT_SIZE_Y;
  assign bus.busy        = (state_q == StLoad);
  assign bus.score       = score_q;

endmodule

// File: tb/tb_platform_bank.sv
// Directed bench for platform_bank: expectations are queued as stimulus is
// driven and popped/compared once the DUT has produced the corresponding output.
module tb_platform_bank;

  logic frame_clk = 1'b0;
  logic Reset;

  platform_bank_if bus ();

  platform_bank dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  localparam int SBusy  = 0;
  localparam int SValid = 1;
  localparam int SScore = 2;
  localparam int SY     = 3;
  localparam int SX     = 4;
  localparam int SSizeX = 5;

  typedef struct {
    string       tag;
    int          sel;
    int          slot;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference random source: Galois right-shift LFSR, tap mask B400, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [8:0] xof(input logic [15:0] l);
    logic [9:0] t;
    t = 10'd40 + {1'b0, l[7:0], 1'b0};
    return t[8:0];
  endfunction

  function automatic logic [15:0] observe(input int sel, input int slot);
    case (sel)
      SBusy:   return {15'd0, bus.busy};
      SValid:  return bus.plat_valid;
      SScore:  return bus.score;
      SY:      return {7'd0, bus.plat_y[slot*9 +: 9]};
      SX:      return {7'd0, bus.plat_x[slot*9 +: 9]};
      default: return {7'd0, bus.plat_size_x};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input int slot,
                            input logic [15:0] exp);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.slot = slot;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel, e.slot);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s slot=%0d observed=%0d expected=%0d", e.tag, e.slot, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic expect_reset_values(input string tag);
    expect_val({tag, "_busy"}, SBusy, 0, 16'd0);
    expect_val({tag, "_valid"}, SValid, 0, 16'd0);
    expect_val({tag, "_score"}, SScore, 0, 16'd0);
    expect_val({tag, "_y0"}, SY, 0, 16'h1FF);
    expect_val({tag, "_y15"}, SY, 15, 16'h1FF);
    expect_val({tag, "_x3"}, SX, 3, 16'd0);
  endtask

  // Full layout load with loadplat held high and a scroll request active.
  task automatic do_load();
    logic [8:0] ex0;
    logic [8:0] ex15;
    ex0  = '0;
    ex15 = '0;
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd7;
    bus.loadplat   = 1'b1;
    tick();
    expect_val("busy_entry", SBusy, 0, 16'd1);
    expect_val("score_clr_entry", SScore, 0, 16'd0);
    check_all();
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  ex0  = xof(m_lfsr);
      if (i == 15) ex15 = xof(m_lfsr);
      expect_val("busy_load", SBusy, 0, (i != 15) ? 16'd1 : 16'd0);
      expect_val("score_load", SScore, 0, 16'd0);
      tick();
      check_all();
    end
    bus.refresh_en = 1'b0;
    expect_val("load_valid", SValid, 0, 16'hFFFF);
    expect_val("load_y0", SY, 0, 16'd470);
    expect_val("load_y7", SY, 7, 16'd260);
    expect_val("load_y15", SY, 15, 16'd20);
    expect_val("load_x0", SX, 0, {7'd0, ex0});
    expect_val("load_x15", SX, 15, {7'd0, ex15});
    expect_val("load_score", SScore, 0, 16'd0);
    check_all();
  endtask

  initial begin
    logic [8:0]  exr;
    logic [16:0] sc;
    Reset          = 1'b1;
    bus.loadplat   = 1'b0;
    bus.refresh_en = 1'b0;
    bus.scroll_amt = 10'd0;

    // Reset state.
    #12;
    expect_reset_values("rst");
    expect_val("size_x", SSizeX, 0, 16'd20);
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;

    // refresh_en in IDLE does nothing.
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd5;
    tick();
    tick();
    expect_val("idle_valid", SValid, 0, 16'd0);
    expect_val("idle_score", SScore, 0, 16'd0);
    expect_val("idle_busy", SBusy, 0, 16'd0);
    check_all();

    // Layout load; loadplat stays high afterwards and must not reload.
    do_load();
    for (int i = 0; i < 3; i++) begin
      expect_val("held_no_reload", SBusy, 0, 16'd0);
      tick();
      check_all();
    end
    bus.loadplat = 1'b0;

    // Scroll by 5 twice: slot0 470 -> 475 -> 480 (dead), then respawns.
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd5;
    expect_val("scr1_y0", SY, 0, 16'd475);
    expect_val("scr1_y15", SY, 15, 16'd25);
    expect_val("scr1_valid", SValid, 0, 16'hFFFF);
    expect_val("scr1_score", SScore, 0, 16'd5);
    tick();
    check_all();
    expect_val("scr2_y0", SY, 0, 16'd480);
    expect_val("scr2_y15", SY, 15, 16'd30);
    expect_val("scr2_valid", SValid, 0, 16'hFFFE);
    expect_val("scr2_score", SScore, 0, 16'd10);
    tick();
    check_all();
    bus.refresh_en = 1'b0;
    exr = xof(m_lfsr);
    expect_val("resp_y0", SY, 0, 16'd25);
    expect_val("resp_x0", SX, 0, {7'd0, exr});
    expect_val("resp_valid", SValid, 0, 16'hFFFF);
    expect_val("resp_score", SScore, 0, 16'd10);
    tick();
    check_all();

    // Zero-pixel scroll leaves everything unchanged.
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd0;
    expect_val("zero_y0", SY, 0, 16'd25);
    expect_val("zero_y15", SY, 15, 16'd30);
    expect_val("zero_valid", SValid, 0, 16'hFFFF);
    expect_val("zero_score", SScore, 0, 16'd10);
    tick();
    check_all();
    bus.refresh_en = 1'b0;

    // Reload from RUN (score clears), then one 70-pixel scroll kills slots 0..2.
    do_load();
    bus.loadplat   = 1'b0;
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd70;
    expect_val("kill3_valid", SValid, 0, 16'hFFF8);
    expect_val("kill3_y0", SY, 0, 16'd28);   // 540 truncated to 9 bits
    expect_val("kill3_y1", SY, 1, 16'd510);
    expect_val("kill3_y3", SY, 3, 16'd450);
    expect_val("kill3_score", SScore, 0, 16'd70);
    tick();
    check_all();
    bus.refresh_en = 1'b0;
    expect_val("resp_a_valid", SValid, 0, 16'hFFF9);
    expect_val("resp_a_y0", SY, 0, 16'd25);
    tick();
    check_all();
    expect_val("resp_b_valid", SValid, 0, 16'hFFFB);
    expect_val("resp_b_y1", SY, 1, 16'd25);
    tick();
    check_all();
    expect_val("resp_c_valid", SValid, 0, 16'hFFFF);
    expect_val("resp_c_y2", SY, 2, 16'd25);
    expect_val("resp_c_score", SScore, 0, 16'd70);
    tick();
    check_all();

    // Max scroll: every add carries out, score saturates.
    bus.refresh_en = 1'b1;
    bus.scroll_amt = 10'd1023;
    for (int k = 1; k <= 66; k++) begin
      sc = 17'd70 + 17'(1023 * k);
      expect_val("sat_score", SScore, 0, (sc > 17'd65535) ? 16'hFFFF : sc[15:0]);
      if (k == 1) begin
        expect_val("ovf_valid", SValid, 0, 16'h0000);
        expect_val("ovf_y0", SY, 0, 16'd24);
      end else if (k == 2) begin
        expect_val("ovf_resp_valid", SValid, 0, 16'h0001);
        expect_val("ovf_resp_y0", SY, 0, 16'd25);
      end else if (k == 3) begin
        expect_val("ovf_resp2_valid", SValid, 0, 16'h0002);
        expect_val("ovf_resp2_y1", SY, 1, 16'd25);
      end
      tick();
      check_all();
    end
    bus.refresh_en = 1'b0;

    // Reset mid-LOAD at idx 7 clears outputs without a clock edge.
    tick();
    bus.loadplat = 1'b1;
    tick();
    repeat (7) tick();
    expect_val("pre_rst_busy", SBusy, 0, 16'd1);
    check_all();
    #2;
    Reset = 1'b1;
    #1;
    expect_reset_values("async_rst");
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
    bus.loadplat = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/platform_bank.md
Name: platform_bank

Overview:
- Owns the 16 on-screen platforms: initial layout, downward scrolling and respawn of platforms that leave the bottom edge.
- Sits directly upstream of the doodle jump-logic stage, which reads its platform X/Y and size outputs for collision.
- Also consumes that stage's scroll request (refresh_en) and scroll amount (plat_temp_Y); this closes the scrolling loop.
- Keeps a running height score from the accumulated scroll distance.

Parameters:
- NUM_PLAT, 16, number of platform slots (fixed at 16 for jump-logic compatibility).
- PLAT_SIZE_X, 9'd20, platform half-width driven on plat_size_x.
- PLAT_SIZE_Y, 9'd3, platform half-height driven on plat_size_y.
- SCREEN_Y_MAX, 10'd479, a platform whose Y exceeds this is dead.
- SPAWN_Y, 10'd25, Y given to a respawned platform.
- LOAD_Y0, 10'd470, Y of slot 0 at load; slot i gets LOAD_Y0 - 30*i.
- X_MIN, 10'd40, leftmost platform X; X = X_MIN + (lfsr[7:0] << 1), range 40..550.
- LFSR_SEED, 16'hACE1, reset value of the random source (must be nonzero).

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  asynchronous, active-high reset.
- loadplat  in  1  level; rising edge sampled on frame_clk starts a layout load.
- refresh_en  in  1  scroll request from jump logic, sampled every frame_clk.
- scroll_amt  in  10  pixels to scroll this frame (plat_temp_Y); unsigned.
- plat_x  out  144  packed 16 x 9-bit X; slot i at [9i+8:9i].
- plat_y  out  144  packed 16 x 9-bit Y, same packing.
- plat_valid  out  16  per-slot live flag.
- plat_size_x  out  9  = PLAT_SIZE_X.
- plat_size_y  out  9  = PLAT_SIZE_Y.
- busy  out  1  high during LOAD.
- score  out  16  saturating accumulated scroll distance.

Behaviour:
- Reset (async, any state) sets:
  - all plat_x = 0, all plat_y = 9'h1FF, plat_valid = 0, score = 0, busy = 0;
  - LFSR = LFSR_SEED, state = IDLE, load index = 0.
- LFSR: 16-bit Galois, right-shift, tap mask 16'hB400. Advances every frame_clk edge in every state.
- Internal Y is 10 bits; plat_y outputs carry the low 9 bits.
- FSM states and transitions:
  - IDLE: waits for a loadplat rising edge, then goes to LOAD.
  - LOAD: busy = 1. Each cycle writes slot idx with Y = LOAD_Y0 - 30*idx and X from the current LFSR, sets valid[idx], then increments idx. After slot 15 is written (exactly 16 cycles) go to RUN with busy = 0. Score clears on LOAD entry.
  - RUN: on each cycle with refresh_en = 1, every valid slot's Y += scroll_amt (10-bit add; carry out counts as dead), and score += scroll_amt, saturating at 16'hFFFF. A slot whose new Y > SCREEN_Y_MAX, or that overflowed, has its valid flag cleared in that same cycle.
  - RUN respawn: each cycle with any valid bit clear, the lowest-index invalid slot gets Y = SPAWN_Y, X from the LFSR, and valid = 1. Only one respawn per cycle.
- Simultaneous scroll and respawn:
  - The respawned slot takes SPAWN_Y unscrolled.
  - The other slots scroll normally.
  - Slots killed this cycle become respawn candidates from the next cycle.
- A loadplat rising edge in RUN restarts LOAD from idx 0. Any edge during LOAD is ignored.
- refresh_en is ignored in IDLE and LOAD.
- scroll_amt = 0 with refresh_en = 1 leaves all outputs unchanged.
- Latency: input sampled at edge N appears on outputs after edge N; outputs are registered.

Optional Feature:
- PLAT_DRIFT_EN defined:
  - Odd-index valid slots move X by ±1 every RUN cycle.
  - Direction is held in a per-slot register (reset = +1).
  - Direction flips when X reaches X_MIN or X_MIN + 510.
  - A respawned slot's direction resets to +1.
- Undefined: X changes only at load or respawn; no direction registers are synthesized.

Test Plan:
- Reset then loadplat 0->1: busy high for 16 cycles; then plat_y slot0 = 470, slot15 = 20, plat_valid = 16'hFFFF, score = 0.
- Scroll kill and respawn:
  - Stimulus: in RUN, refresh_en = 1 with scroll_amt = 5 for 2 cycles.
  - Slot0 Y 470 -> 475 -> 480; valid[0] = 0 after cycle 2.
  - Next cycle: slot0 Y = 25, valid[0] = 1.
  - score = 10.
- Three slots dead at once: single scroll with scroll_amt = 70 kills slots 0, 1 and 2. They respawn in index order over 3 consecutive cycles, each at Y = 25.
- Score saturation and overflow kill: score preloaded near max via repeated scroll_amt = 1023 -> score sticks at 16'hFFFF. Any Y add with carry out kills that slot.
- Reset mid-operation: assert Reset during LOAD at idx 7 -> all outputs return to reset values immediately, without waiting for a clock edge.
- Edge-case inputs:
  - loadplat held high through LOAD: only one load occurs.
  - refresh_en during LOAD: no Y change and score stays 0.
  - With PLAT_DRIFT_EN: slot1 X alternates direction at the bounds.
